buffer_arbiter: RTL

Round-robin arbiter that shares the single 35-bit memory-write path between four input buffers. It grants one requester at a time and holds the grant for the full multi-word packet while bit 34 is set. It drives a registered output stage toward the memory interface and honours both the downstream `next_ready` and the `mem_full` backpressure. It sequences the same four-buffer datapath as the existing buffer mux and replaces its zero-word idle convention with explicit request/ready handshakes.

---
 rtl/buffer_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 29 ++
 rtl/buffer_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/buffer_arb_pkg.sv
// buffer_arb_pkg: shared types and constants for the four-way buffer arbiter.
//   NUM_REQ  - number of input buffers sharing the memory-write path
//   DATA_W   - word width (continuation flag + payload)
//   CONT_BIT - position of the "more words follow" flag
//   arb_state_e - arbiter FSM states
package buffer_arb_pkg;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_W   = 35;
    localparam int unsigned CONT_BIT = 34;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational 4-way rotate-priority encoder.
//   req    in  4  request vector
//   ptr    in  2  highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   any    out 1  at least one request is high
//   winner out 2  first requester found in search order (ptr when none)
module rr_picker (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] winner
);

    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        idx    = ptr;
        winner = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin arbiter sharing one 35-bit memory-write path between four
// input buffers. A grant is held for a whole packet (bit 34 set = more words follow).
//   clk, reset              clock; asynchronous active-low reset
//   req0..3 / in_data0..3   per-buffer valid flag and word
//   ready0..3               word consumed this cycle when the matching req is high
//   next_ready, mem_full    downstream accept and memory-full backpressure
//   out_data, out_valid     registered output word
//   cur_sel                 current or most recent grant
//   timeout_err             sticky lock-timeout flag (only with BUFFER_ARB_TIMEOUT_EN)
// Optional feature macro: BUFFER_ARB_TIMEOUT_EN enables the stalled-lock timeout.
module buffer_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              req3,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic              ready0,
    output logic              ready1,
    output logic              ready2,
    output logic              ready3,
    input  logic              next_ready,
    input  logic              mem_full,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
`ifdef BUFFER_ARB_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [1:0]        cur_sel
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_e        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        cur_sel_q, cur_sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] ready_vec;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [DATA_W-1:0]  sel_data;
    logic               ready_sel;
    logic               accept;
    logic               pick_any;
    logic [1:0]         pick_winner;

    assign req_vec     = {req3, req2, req1, req0};
    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;
    assign sel_data    = data_arr[cur_sel_q];

    rr_picker u_picker (
        .req    (req_vec),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Deliberately independent of req so there is no req->ready combinational loop upstream.
    assign ready_sel = (state_q == StLock) && (!out_valid_q || next_ready) && !mem_full;
    assign ready_vec = ready_sel ? (4'b0001 << cur_sel_q) : '0;
    assign accept    = ready_sel && req_vec[cur_sel_q];

    assign ready0    = ready_vec[0];
    assign ready1    = ready_vec[1];
    assign ready2    = ready_vec[2];
    assign ready3    = ready_vec[3];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;

`ifdef BUFFER_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    assign timeout_err = timeout_err_q;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_sel_d   = cur_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef BUFFER_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        // Drain first; a same-cycle acceptance overrides and keeps the stage full.
        if (out_valid_q && next_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    cur_sel_d = pick_winner;
                    state_d   = StLock;
`ifdef BUFFER_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            StLock: begin
                if (accept) begin
`ifdef BUFFER_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (!sel_data[CONT_BIT]) begin
                        state_d = StIdle;
                        ptr_d   = cur_sel_q + 2'd1;
                    end
                end
`ifdef BUFFER_ARB_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                    if (({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES)) begin
                        state_d       = StIdle;
                        ptr_d         = cur_sel_q + 2'd1;
                        timeout_err_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cur_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_sel_q   <= cur_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BUFFER_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

endmodule
